// File: rtl/sad_if.sv
// Handshake bundle between the magnitude subtractor, the SAD accumulator and the SAD consumer.
// The slave modport is the accumulator's view of the bundle; the master modport is its peers' view.
interface sad_if #(
    parameter int DW = 4,
    parameter int AW = 7
);
    logic [DW-1:0] diff_in;
    logic          diff_valid;
    logic          diff_ready;
    logic [AW-1:0] sad_out;
    logic          sad_valid;
    logic          sad_ready;

    modport slave (
        input  diff_in,
        input  diff_valid,
        output diff_ready,
        output sad_out,
        output sad_valid,
        input  sad_ready
    );

    modport master (
        output diff_in,
        output diff_valid,
        input  diff_ready,
        input  sad_out,
        input  sad_valid,
        output sad_ready
    );
endinterface

// File: rtl/sad_accumulator.sv
// Sums LEN unsigned differences into one SAD word and holds it on a valid/ready output.
// Optional macro SAD_SAT_EN: clamp the accumulator at 2^AW-1 and report it on sat_flag_o.
//
//   state    | meaning
//   ST_ACCUM | accepting differences, building the partial sum
//   ST_HOLD  | SAD word valid, waiting for the consumer; input stalled
module sad_accumulator #(
    parameter int DW  = 4,
    parameter int LEN = 8,
    parameter int AW  = 7
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr_i,
    sad_if.slave       bus,
    output logic [7:0] count_o,
    output logic       sat_flag_o
);

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] acc_q, acc_d;
    logic [AW-1:0] sad_q, sad_d;
    logic [7:0]    count_q, count_d;
    logic          sad_valid_q, sad_valid_d;
    logic [AW-1:0] sum;
    logic          last;

`ifdef SAD_SAT_EN
    logic [AW:0] sum_wide;
    logic        sat_hit;
    logic        sat_q, sat_d;

    assign sum_wide   = {1'b0, acc_q} + (AW+1)'(bus.diff_in);
    assign sat_hit    = sum_wide[AW];
    assign sum        = sat_hit ? '1 : sum_wide[AW-1:0];
    assign sat_flag_o = sat_q;
`else
    assign sum        = acc_q + AW'(bus.diff_in);
    assign sat_flag_o = 1'b0;
`endif

    assign last           = (count_q == 8'(LEN - 1));
    assign bus.diff_ready = (state_q == ST_ACCUM);
    assign bus.sad_out    = sad_q;
    assign bus.sad_valid  = sad_valid_q;
    assign count_o        = count_q;

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        count_d     = count_q;
        sad_d       = sad_q;
        sad_valid_d = sad_valid_q;
`ifdef SAD_SAT_EN
        sat_d       = sat_q;
`endif
        // clr beats any same-cycle accept or consumer handshake; the held SAD word is kept but invalidated
        if (clr_i) begin
            state_d     = ST_ACCUM;
            acc_d       = '0;
            count_d     = '0;
            sad_valid_d = 1'b0;
`ifdef SAD_SAT_EN
            sat_d       = 1'b0;
`endif
        end else begin
            unique case (state_q)
                ST_ACCUM: begin
                    if (bus.diff_valid) begin
`ifdef SAD_SAT_EN
                        if (sat_hit) sat_d = 1'b1;
`endif
                        if (last) begin
                            sad_d       = sum;
                            sad_valid_d = 1'b1;
                            acc_d       = '0;
                            count_d     = '0;
                            state_d     = ST_HOLD;
                        end else begin
                            acc_d   = sum;
                            count_d = count_q + 8'd1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (sad_valid_q && bus.sad_ready) begin
                        sad_valid_d = 1'b0;
                        state_d     = ST_ACCUM;
`ifdef SAD_SAT_EN
                        sat_d       = 1'b0;
`endif
                    end
                end
                default: state_d = ST_ACCUM;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_ACCUM;
            acc_q       <= '0;
            count_q     <= '0;
            sad_q       <= '0;
            sad_valid_q <= 1'b0;
`ifdef SAD_SAT_EN
            sat_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            count_q     <= count_d;
            sad_q       <= sad_d;
            sad_valid_q <= sad_valid_d;
`ifdef SAD_SAT_EN
            sat_q       <= sat_d;
`endif
        end
    end

endmodule
